// File: rtl/mem_access_unit.sv
// Data-memory access unit for the MEM stage: launches aligned loads/stores onto a simple
// req/ack bus, stalls the pipeline until the bus answers or times out, and extends load data.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        flushM,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [3:0]  dm_be,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        stall_req,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        bus_err
);

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  localparam logic [15:0] LimitM1 = 16'(TIMEOUT_CYCLES - 1);

  state_e      r_state;
  logic [15:0] r_cnt;
  logic [31:0] r_addr;
  logic [2:0]  r_funct3;
  logic        r_we;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [31:0] r_load_data;

  logic        w_legal;
  logic        w_aligned;
  logic        w_cand;
  logic        w_access;
  logic        w_timeout;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_lane;
  logic [31:0] w_ext;

  // Decode size legality, alignment and the bus lanes for a store.
  always_comb begin
    w_legal   = 1'b0;
    w_aligned = 1'b1;
    case (funct3)
      3'b000, 3'b100: w_legal = 1'b1;
      3'b001, 3'b101: begin
        w_legal   = 1'b1;
        w_aligned = ~addr[0];
      end
      3'b010: begin
        w_legal   = 1'b1;
        w_aligned = (addr[1:0] == 2'b00);
      end
      default: w_legal = 1'b0;
    endcase

    w_be    = 4'b1111;
    w_wdata = '0;
    if (mem_write) begin
      case (funct3[1:0])
        2'b00: begin
          w_be    = 4'b0001 << addr[1:0];
          w_wdata = {4{wdata[7:0]}};
        end
        2'b01: begin
          w_be    = addr[1] ? 4'b1100 : 4'b0011;
          w_wdata = {2{wdata[15:0]}};
        end
        default: begin
          w_be    = 4'b1111;
          w_wdata = wdata;
        end
      endcase
    end
  end

  assign w_cand     = rst_n & (r_state == StIdle) & (mem_read | mem_write) & ~flushM & w_legal;
  assign w_access   = w_cand & w_aligned;
  assign misaligned = w_cand & ~w_aligned;

  // Ack in the limit cycle wins over the timeout.
  assign w_timeout = (r_state == StReq) & ~dm_ack & (r_cnt == LimitM1);
  assign bus_err   = w_timeout;

  assign stall_req = w_access | (r_state == StReq);

  assign dm_req   = (r_state == StReq);
  assign dm_we    = dm_req & r_we;
  assign dm_be    = dm_req ? r_be : 4'b0000;
  assign dm_addr  = dm_req ? {r_addr[31:2], 2'b00} : 32'h0;
  assign dm_wdata = dm_req ? r_wdata : 32'h0;

  assign w_lane = dm_rdata >> {r_addr[1:0], 3'b000};

  always_comb begin
    w_ext = dm_rdata;
    case (r_funct3)
      3'b000:  w_ext = {{24{w_lane[7]}}, w_lane[7:0]};
      3'b001:  w_ext = {{16{w_lane[15]}}, w_lane[15:0]};
      3'b100:  w_ext = {24'h0, w_lane[7:0]};
      3'b101:  w_ext = {16'h0, w_lane[15:0]};
      default: w_ext = dm_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_funct3    <= '0;
      r_we        <= 1'b0;
      r_be        <= '0;
      r_wdata     <= '0;
      r_load_data <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_access) begin
            r_state  <= StReq;
            r_cnt    <= '0;
            r_addr   <= addr;
            r_funct3 <= funct3;
            r_we     <= mem_write;
            r_be     <= w_be;
            r_wdata  <= w_wdata;
          end
        end
        StReq: begin
          if (dm_ack) begin
            r_state <= StDone;
            if (!r_we) r_load_data <= w_ext;
          end else if (w_timeout) begin
            r_state <= StDone;
            if (!r_we) r_load_data <= '0;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        StDone:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  assign load_data = r_load_data;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with TIMEOUT_CYCLES=4; each task drives one scenario
// and checks it against hand-computed values.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read, mem_write, flushM, dm_ack;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, dm_rdata;
  logic        dm_req, dm_we, stall_req, misaligned, bus_err;
  logic [31:0] dm_addr, dm_wdata, load_data;
  logic [3:0]  dm_be;

  int checks = 0;
  int errors = 0;

  // Observations of the last access driven by run_access.
  int          n_stall, n_req, n_mis, n_berr;
  bit          unstable, ended;
  logic [31:0] rec_addr, rec_wdata;
  logic [3:0]  rec_be;
  logic        rec_we;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
    .addr(addr), .wdata(wdata), .flushM(flushM), .dm_req(dm_req), .dm_we(dm_we),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be), .dm_ack(dm_ack),
    .dm_rdata(dm_rdata), .stall_req(stall_req), .load_data(load_data),
    .misaligned(misaligned), .bus_err(bus_err)
  );

  // Drives one MEM-stage instruction and acts as the memory; ack_at is the REQ cycle
  // (1-based) that gets dm_ack, 0 means never. Starts and ends just after a rising edge.
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd, input int ack_at,
                            input logic [31:0] word, input bit flush_mid);
    n_stall = 0; n_req = 0; n_mis = 0; n_berr = 0; unstable = 0; ended = 0;
    mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd; flushM = 1'b0;
    for (int c = 0; c < 40 && !ended; c++) begin
      dm_ack = 1'b0;
      if (dm_req) begin
        n_req++;
        if (n_req == ack_at) begin
          dm_ack   = 1'b1;
          dm_rdata = word;
        end
        if (flush_mid && n_req == 2) flushM = 1'b1;
      end
      #1;
      if (stall_req) n_stall++;
      if (misaligned) n_mis++;
      if (bus_err) n_berr++;
      if (dm_req) begin
        if (n_req == 1) begin
          rec_addr = dm_addr; rec_wdata = dm_wdata; rec_be = dm_be; rec_we = dm_we;
        end else if (dm_addr !== rec_addr || dm_wdata !== rec_wdata || dm_be !== rec_be ||
                     dm_we !== rec_we) begin
          unstable = 1;
        end
      end
      if (c > 0 && !stall_req) ended = 1;
      @(posedge clk); #1;
      mem_read = 1'b0; mem_write = 1'b0; flushM = 1'b0; dm_ack = 1'b0;
    end
    checks++;
    if (!ended) begin
      errors++;
      $display("FAIL access_end: access did not finish within 40 cycles");
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_read = 0; mem_write = 0; flushM = 0; dm_ack = 0;
    funct3 = 3'b010; addr = '0; wdata = '0; dm_rdata = '0;
    #3;
    checks++;
    if ({dm_req, stall_req, misaligned, bus_err, dm_be} !== 8'h00 || load_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: req=%b stall=%b mis=%b berr=%b be=%b ld=%h want all 0",
               dm_req, stall_req, misaligned, bus_err, dm_be, load_data);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_lw();
    run_access(1, 0, 3'b010, 32'h100, 32'h0, 3, 32'hDEADBEEF, 0);
    checks++;
    if (n_stall !== 4 || n_req !== 3) begin
      errors++;
      $display("FAIL lw_timing: stall=%0d req=%0d want 4 3", n_stall, n_req);
    end
    checks++;
    if (rec_addr !== 32'h100 || rec_be !== 4'b1111 || rec_we !== 1'b0 || rec_wdata !== 32'h0) begin
      errors++;
      $display("FAIL lw_bus: addr=%h be=%b we=%b wd=%h want 100 1111 0 0",
               rec_addr, rec_be, rec_we, rec_wdata);
    end
    checks++;
    if (load_data !== 32'hDEADBEEF || n_berr !== 0 || unstable) begin
      errors++;
      $display("FAIL lw_data: ld=%h berr=%0d unstable=%0d want deadbeef 0 0",
               load_data, n_berr, unstable);
    end
    checks++;
    if (dm_req !== 1'b0 || stall_req !== 1'b0) begin
      errors++;
      $display("FAIL lw_idle_after: req=%b stall=%b want 0 0", dm_req, stall_req);
    end
  endtask

  task automatic test_load_ext();
    run_access(1, 0, 3'b000, 32'h103, 32'h0, 1, 32'h80FFFF00, 0);
    checks++;
    if (load_data !== 32'hFFFFFF80) begin
      errors++;
      $display("FAIL lb_sext: got %h want ffffff80", load_data);
    end
    run_access(1, 0, 3'b100, 32'h103, 32'h0, 2, 32'h80FFFF00, 0);
    checks++;
    if (load_data !== 32'h00000080) begin
      errors++;
      $display("FAIL lbu_zext: got %h want 00000080", load_data);
    end
    run_access(1, 0, 3'b101, 32'h102, 32'h0, 1, 32'h80FFFF00, 0);
    checks++;
    if (load_data !== 32'h000080FF || rec_addr !== 32'h100) begin
      errors++;
      $display("FAIL lhu_zext: got %h addr %h want 000080ff 00000100", load_data, rec_addr);
    end
    run_access(1, 0, 3'b001, 32'h102, 32'h0, 1, 32'h80FFFF00, 0);
    checks++;
    if (load_data !== 32'hFFFF80FF) begin
      errors++;
      $display("FAIL lh_sext: got %h want ffff80ff", load_data);
    end
  endtask

  task automatic test_store();
    run_access(0, 1, 3'b000, 32'h201, 32'h12345678, 1, 32'hAAAAAAAA, 0);
    checks++;
    if (rec_be !== 4'b0010 || rec_wdata !== 32'h78787878 || rec_we !== 1'b1 ||
        rec_addr !== 32'h200) begin
      errors++;
      $display("FAIL sb_bus: be=%b wd=%h we=%b addr=%h want 0010 78787878 1 200",
               rec_be, rec_wdata, rec_we, rec_addr);
    end
    checks++;
    if (load_data !== 32'hFFFF80FF) begin
      errors++;
      $display("FAIL store_keeps_load: got %h want ffff80ff", load_data);
    end
    // Read and write together behave as a store.
    run_access(1, 1, 3'b001, 32'h202, 32'h12345678, 2, 32'hAAAAAAAA, 0);
    checks++;
    if (rec_be !== 4'b1100 || rec_wdata !== 32'h56785678 || rec_we !== 1'b1 ||
        load_data !== 32'hFFFF80FF) begin
      errors++;
      $display("FAIL sh_bus: be=%b wd=%h we=%b ld=%h want 1100 56785678 1 ffff80ff",
               rec_be, rec_wdata, rec_we, load_data);
    end
    run_access(0, 1, 3'b010, 32'h204, 32'hCAFEF00D, 1, 32'h0, 0);
    checks++;
    if (rec_be !== 4'b1111 || rec_wdata !== 32'hCAFEF00D || n_stall !== 2) begin
      errors++;
      $display("FAIL sw_bus: be=%b wd=%h stall=%0d want 1111 cafef00d 2",
               rec_be, rec_wdata, n_stall);
    end
  endtask

  task automatic test_misaligned();
    run_access(1, 0, 3'b010, 32'h102, 32'h0, 1, 32'h0, 0);
    checks++;
    if (n_mis !== 1 || n_req !== 0 || n_stall !== 0) begin
      errors++;
      $display("FAIL lw_misaligned: mis=%0d req=%0d stall=%0d want 1 0 0", n_mis, n_req, n_stall);
    end
    run_access(0, 1, 3'b001, 32'h101, 32'h0, 1, 32'h0, 0);
    checks++;
    if (n_mis !== 1 || n_req !== 0 || n_stall !== 0) begin
      errors++;
      $display("FAIL sh_misaligned: mis=%0d req=%0d stall=%0d want 1 0 0", n_mis, n_req, n_stall);
    end
    run_access(1, 0, 3'b011, 32'h100, 32'h0, 1, 32'h0, 0);
    checks++;
    if (n_mis !== 0 || n_req !== 0 || n_stall !== 0) begin
      errors++;
      $display("FAIL illegal_f3: mis=%0d req=%0d stall=%0d want 0 0 0", n_mis, n_req, n_stall);
    end
  endtask

  task automatic test_flush_idle();
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h102; flushM = 1'b1;
    dm_ack = 1'b1; dm_rdata = 32'h11111111;
    #1;
    checks++;
    if (stall_req !== 1'b0 || misaligned !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle: stall=%b mis=%b want 0 0", stall_req, misaligned);
    end
    @(posedge clk); #1;
    checks++;
    if (dm_req !== 1'b0 || load_data !== 32'hFFFF80FF) begin
      errors++;
      $display("FAIL flush_no_req: req=%b ld=%h want 0 ffff80ff", dm_req, load_data);
    end
    mem_read = 1'b0; flushM = 1'b0; dm_ack = 1'b0;
  endtask

  task automatic test_timeout();
    run_access(1, 0, 3'b010, 32'h300, 32'h0, 4, 32'h5A5A5A5A, 0);
    checks++;
    if (n_berr !== 0 || load_data !== 32'h5A5A5A5A || n_req !== 4) begin
      errors++;
      $display("FAIL ack_at_limit: berr=%0d ld=%h req=%0d want 0 5a5a5a5a 4",
               n_berr, load_data, n_req);
    end
    run_access(1, 0, 3'b010, 32'h304, 32'h0, 0, 32'h0, 1);
    checks++;
    if (n_berr !== 1 || n_req !== 4 || n_stall !== 5) begin
      errors++;
      $display("FAIL timeout_timing: berr=%0d req=%0d stall=%0d want 1 4 5",
               n_berr, n_req, n_stall);
    end
    checks++;
    if (load_data !== 32'h0 || dm_req !== 1'b0 || bus_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_result: ld=%h req=%b berr=%b want 0 0 0", load_data, dm_req, bus_err);
    end
  endtask

  task automatic test_reset_mid_req();
    run_access(1, 0, 3'b010, 32'h104, 32'h0, 1, 32'h0BADF00D, 0);
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h108;
    @(posedge clk); #1;
    mem_read = 1'b0;
    checks++;
    if (dm_req !== 1'b1) begin
      errors++;
      $display("FAIL mid_req_entry: req=%b want 1", dm_req);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (dm_req !== 1'b0 || stall_req !== 1'b0 || load_data !== 32'h0) begin
      errors++;
      $display("FAIL async_reset: req=%b stall=%b ld=%h want 0 0 0", dm_req, stall_req, load_data);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_access(1, 0, 3'b010, 32'h10C, 32'h0, 2, 32'h13579BDF, 0);
    checks++;
    if (load_data !== 32'h13579BDF || n_stall !== 3 || n_berr !== 0) begin
      errors++;
      $display("FAIL after_reset_lw: ld=%h stall=%0d berr=%0d want 13579bdf 3 0",
               load_data, n_stall, n_berr);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_load_ext();
    test_store();
    test_misaligned();
    test_flush_idle();
    test_timeout();
    test_reset_mid_req();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 255, max cycles dm_req may wait for dm_ack before bus error (1..65535).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 mem_read  input  1  MEM-stage instruction is a load.
REQ-005 mem_write  input  1  MEM-stage instruction is a store.
REQ-006 funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 addr  input  32  effective address (registered EX result in MEM stage).
REQ-008 wdata  input  32  store data, right-aligned.
REQ-009 flushM  input  1  MEM-stage instruction is killed.
REQ-010 dm_req  output  1  memory request valid.
REQ-011 dm_we  output  1  1 = write, 0 = read.
REQ-012 dm_addr  output  32  word address, {addr[31:2],2'b00}.
REQ-013 dm_wdata  output  32  lane-replicated store data.
REQ-014 dm_be  output  4  byte enables.
REQ-015 dm_ack  input  1  memory completes request this cycle.
REQ-016 dm_rdata  input  32  read word, valid when dm_ack=1.
REQ-017 stall_req  output  1  freeze pipeline (drives bubble to IF/ID/EX/MEM registers).
REQ-018 load_data  output  32  extended load result, registered.
REQ-019 misaligned  output  1  one-cycle pulse, misaligned access dropped.
REQ-020 bus_err  output  1  one-cycle pulse, request timed out.

Function
REQ-021 States IDLE, REQ, DONE; encoding free.
REQ-022 IDLE: access = (mem_read|mem_write) & ~flushM & legal funct3 & aligned; on access go REQ, capture addr/funct3/we/wdata internally.
REQ-023 stall_req SHALL be combinational: 1 in IDLE when access launches, 1 throughout REQ, 0 in IDLE without access and in DONE.
REQ-024 REQ: dm_req=1 with dm_addr/dm_we/dm_be/dm_wdata stable from captured values until the cycle dm_ack=1 (inclusive).
REQ-025 dm_ack in REQ -> DONE next edge; for reads load_data updated at same edge.
REQ-026 DONE lasts exactly one cycle, stall_req=0 so pipeline advances; then IDLE. No new launch from DONE.
REQ-027 dm_ack outside REQ ignored.
REQ-028 mem_read and mem_write both 1: treated as store.
REQ-029 Alignment: H/HU need addr[0]=0; W needs addr[1:0]=00; violation -> misaligned=1 for that cycle, no request, no stall, state stays IDLE.
REQ-030 funct3 011/110/111 or flushM=1 in IDLE: no request, no stall, no pulse.
REQ-031 flushM during REQ ignored; transaction completes (bus cannot be abandoned).
REQ-032 Store be: B -> 4'b0001<<addr[1:0], data {4{wdata[7:0]}}; H -> 0011 (addr[1]=0) / 1100, data {2{wdata[15:0]}}; W -> 1111, wdata.
REQ-033 Read: dm_be=1111, dm_wdata=0.
REQ-034 Load extension: lane selected by addr[1:0]; B/H sign-extend, BU/HU zero-extend, W unchanged.
REQ-035 Stores leave load_data unchanged.
REQ-036 Wait counter clears on REQ entry, increments each REQ cycle without dm_ack; reaching TIMEOUT_CYCLES -> bus_err=1 one cycle, dm_req drops, load_data=0 if read, go DONE.
REQ-037 dm_ack in the same cycle the counter reaches limit: ack wins, no bus_err.
REQ-038 Idle outputs: dm_req=0, dm_we=0, dm_be=0.

Reset
REQ-039 rst_n=0 -> state IDLE, counter 0, load_data=0, all pulses 0, dm_req=0, stall_req=0, immediately and independent of clk.
REQ-040 Reset mid-REQ aborts request; dm_req falls asynchronously.

Verification
REQ-041 LW addr=0x100, dm_ack 3 cycles after dm_req, dm_rdata=0xDEADBEEF -> stall_req 4 cycles, dm_addr=0x100, load_data=0xDEADBEEF, one DONE cycle.
REQ-042 LB addr=0x103, rdata=0x80FF_FF00 -> load_data=0xFFFFFF80; LBU same -> 0x00000080; LHU addr=0x102 -> 0x000080FF.
REQ-043 SB addr=0x201 wdata=0x12345678 -> dm_be=0010, dm_wdata=0x78787878, dm_we=1; SH addr=0x202 -> be=1100, dm_wdata=0x56785678.
REQ-044 LW addr=0x102 -> misaligned pulse 1 cycle, dm_req never 1, stall_req 0; SH addr=0x101 same.
REQ-045 TIMEOUT_CYCLES=4, LW with no dm_ack -> bus_err on 4th REQ cycle, load_data=0, DONE, IDLE; flushM asserted mid-REQ does not shorten transaction.
REQ-046 rst_n low during REQ -> dm_req and stall_req 0 without clock edge; after release, new LW completes normally.
